// File: rtl/mpadder_serial.sv
// mpadder_serial: limb-serial multi-precision adder/subtractor.
// Operands are consumed LIMB_W bits per clock with a registered carry.
// Subtraction uses A + ~B + 1; result[WIDTH] carries the add carry-out,
// or the borrow (A<B) for subtraction.
// Optional feature macro: MPADDER_FLAGS_EN (adds the registered zero flag).
module mpadder_serial #(
    parameter int WIDTH  = 1024,
    parameter int LIMB_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             done
`ifdef MPADDER_FLAGS_EN
    ,
    output logic             zero
`endif
);

    localparam int LIMBS = WIDTH / LIMB_W;
    localparam int CNT_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(LIMBS - 1);

    generate
        if (LIMB_W < 1 || LIMB_W > WIDTH) begin : g_bad_limb
            $error("mpadder_serial: LIMB_W must satisfy 1 <= LIMB_W <= WIDTH");
        end else if (WIDTH % LIMB_W != 0) begin : g_bad_width
            $error("mpadder_serial: WIDTH must be a multiple of LIMB_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic               sub_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH:0]     result_q;
    logic               done_q;

    logic [LIMB_W:0]    sum_d;
    logic [WIDTH-1:0]   limb_ext_d;
    logic [WIDTH-1:0]   acc_d;

    // One limb of the ripple: low limbs of both operands plus the stored carry.
    assign sum_d = {1'b0, op_a_q[LIMB_W-1:0]} + {1'b0, op_b_q[LIMB_W-1:0]}
                 + {{LIMB_W{1'b0}}, carry_q};

    // New limb enters at the top; after LIMBS cycles limb 0 has reached bit 0,
    // so each limb ends up at the position given by its counter value.
    assign limb_ext_d = WIDTH'(sum_d[LIMB_W-1:0]);
    assign acc_d      = (acc_q >> LIMB_W) | (limb_ext_d << (WIDTH - LIMB_W));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only counts in IDLE; RUN lasts exactly LIMBS cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_LIMB) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: busy covers the whole operation, RUN and DONE.
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Datapath: operand capture, limb-serial add, and result publication.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_a_q  <= in_a;
                        op_b_q  <= in_b ^ {WIDTH{subtract}};
                        sub_q   <= subtract;
                        carry_q <= subtract;
                        cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= sum_d[LIMB_W];
                    op_a_q  <= op_a_q >> LIMB_W;
                    op_b_q  <= op_b_q >> LIMB_W;
                    cnt_q   <= cnt_q + 1'b1;
                end
                S_DONE: begin
                    result_q <= {carry_q ^ sub_q, acc_q};
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;

`ifdef MPADDER_FLAGS_EN
    logic zacc_q;
    logic zero_q;

    // Zero flag: AND of per-limb zero tests, published together with result.
    always_ff @(posedge clk) begin
        if (reset) begin
            zacc_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        zacc_q <= 1'b1;
                        zero_q <= 1'b0;
                    end
                end
                S_RUN:  zacc_q <= zacc_q & (sum_d[LIMB_W-1:0] == '0);
                S_DONE: zero_q <= zacc_q;
                default: ;
            endcase
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_mpadder_serial.sv
// Testbench for mpadder_serial: three instances (16/4, 1024/64, 8/8)
// driven with directed vectors; expected values are computed here.
module tb_mpadder_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    // 16-bit, 4-bit limbs
    logic        s_start = 0, s_sub = 0;
    logic [15:0] s_a = '0, s_b = '0;
    logic [16:0] s_res;
    logic        s_busy, s_done, s_zero;
    // 1024-bit, 64-bit limbs
    logic          w_start = 0, w_sub = 0;
    logic [1023:0] w_a = '0, w_b = '0;
    logic [1024:0] w_res;
    logic          w_busy, w_done, w_zero;
    // 8-bit, single limb
    logic       n_start = 0, n_sub = 0;
    logic [7:0] n_a = '0, n_b = '0;
    logic [8:0] n_res;
    logic       n_busy, n_done, n_zero;

    mpadder_serial #(.WIDTH(16), .LIMB_W(4)) u_s (
        .clk(clk), .reset(rst), .start(s_start), .subtract(s_sub),
        .in_a(s_a), .in_b(s_b), .result(s_res), .busy(s_busy), .done(s_done)
`ifdef MPADDER_FLAGS_EN
        , .zero(s_zero)
`endif
    );

    mpadder_serial #(.WIDTH(1024), .LIMB_W(64)) u_w (
        .clk(clk), .reset(rst), .start(w_start), .subtract(w_sub),
        .in_a(w_a), .in_b(w_b), .result(w_res), .busy(w_busy), .done(w_done)
`ifdef MPADDER_FLAGS_EN
        , .zero(w_zero)
`endif
    );

    mpadder_serial #(.WIDTH(8), .LIMB_W(8)) u_n (
        .clk(clk), .reset(rst), .start(n_start), .subtract(n_sub),
        .in_a(n_a), .in_b(n_b), .result(n_res), .busy(n_busy), .done(n_done)
`ifdef MPADDER_FLAGS_EN
        , .zero(n_zero)
`endif
    );

`ifndef MPADDER_FLAGS_EN
    assign s_zero = 1'b0;
    assign w_zero = 1'b0;
    assign n_zero = 1'b0;
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 16-bit unit and watch a fixed 20-cycle window.
    // lat = edges after the accept edge at which done is first seen.
    // rep re-pulses start (with other operands) toward edges 2 and 5.
    task automatic run16(input logic sub, input logic [15:0] a, input logic [15:0] b,
                         input bit rep, output logic [16:0] res, output logic z,
                         output int lat, output int nbusy, output int ndone);
        s_sub = sub; s_a = a; s_b = b; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_a = ~a; s_b = 16'h1234; s_sub = ~sub;
        lat = -1; nbusy = 0; ndone = 0; res = 'x; z = 1'bx;
        for (int k = 0; k < 20; k++) begin
            if (s_busy) nbusy++;
            if (s_done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k; res = s_res; z = s_zero;
                end
            end
            s_start = rep && (k == 1 || k == 4);
            @(posedge clk); #1;
        end
        s_start = 1'b0;
    endtask

    // Issue one op on the 8-bit unit; returns right after done is seen.
    task automatic run8(input logic sub, input logic [7:0] a, input logic [7:0] b,
                        output logic [8:0] res, output int lat);
        n_sub = sub; n_a = a; n_b = b; n_start = 1'b1;
        @(posedge clk); #1;
        n_start = 1'b0; n_a = 8'h5A; n_b = 8'hC3;
        lat = -1; res = 'x;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (n_done) begin
                lat = k; res = n_res;
            end
        end
    endtask

    // Issue one op on the 1024-bit unit; returns right after done is seen.
    task automatic runw(input logic sub, input logic [1023:0] a, input logic [1023:0] b,
                        output logic [1024:0] res, output logic z, output int lat);
        w_sub = sub; w_a = a; w_b = b; w_start = 1'b1;
        @(posedge clk); #1;
        w_start = 1'b0; w_a = ~a; w_b = '0;
        lat = -1; res = 'x; z = 1'bx;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (w_done) begin
                lat = k; res = w_res; z = w_zero;
            end
        end
    endtask

    logic [16:0]   r16;
    logic [8:0]    r8;
    logic [1024:0] rw;
    logic [1087:0] wa, wb, wexp, wres;
    logic          z;
    int            lat, nbusy, ndone;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res16", 128'(s_res), 128'h0);
        chk("rst_busy16", 128'(s_busy), 128'h0);
        chk("rst_done16", 128'(s_done), 128'h0);
        chk("rst_resw_lo", 128'(w_res[127:0]), 128'h0);
        chk("rst_busyw", 128'(w_busy), 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: 0xFFFF + 0x0001
        run16(1'b0, 16'hFFFF, 16'h0001, 1'b0, r16, z, lat, nbusy, ndone);
        chk("t1_res", 128'(r16), 128'h10000);
        chk("t1_lat", 128'(lat), 128'd5);
        chk("t1_busy_cycles", 128'(nbusy), 128'd5);
        chk("t1_done_pulses", 128'(ndone), 128'd1);

        // Test 2: 0x0003 - 0x0005
        run16(1'b1, 16'h0003, 16'h0005, 1'b0, r16, z, lat, nbusy, ndone);
        chk("t2_res", 128'(r16), 128'h1FFFE);
        chk("t2_hold", 128'(s_res), 128'h1FFFE);
`ifdef MPADDER_FLAGS_EN
        chk("t2_zero", 128'(z), 128'h0);
`endif

        // Test 4: start re-pulsed while busy is ignored
        run16(1'b0, 16'h1234, 16'h4321, 1'b1, r16, z, lat, nbusy, ndone);
        chk("t4_res", 128'(r16), 128'h05555);
        chk("t4_done_pulses", 128'(ndone), 128'd1);
        chk("t4_lat", 128'(lat), 128'd5);

        // Test 5: reset on the third RUN edge aborts the op
        s_sub = 1'b0; s_a = 16'h00FF; s_b = 16'h0001; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_res_cleared", 128'(s_res), 128'h0);
        chk("t5_busy", 128'(s_busy), 128'h0);
        chk("t5_done", 128'(s_done), 128'h0);
        run16(1'b0, 16'h00FF, 16'h0001, 1'b0, r16, z, lat, nbusy, ndone);
        chk("t5_fresh_res", 128'(r16), 128'h00100);
        chk("t5_fresh_done_pulses", 128'(ndone), 128'd1);

        // Test 3: 1024-bit A - A gives zero
        wa = '0;
        for (int i = 0; i < 32; i++) wa[i*32 +: 32] = $urandom;
        wb = wa;
        runw(1'b1, wa[1023:0], wb[1023:0], rw, z, lat);
        chk("t3_low_nonzero", 128'(|rw[1023:0]), 128'h0);
        chk("t3_bit1024", 128'(rw[1024]), 128'h0);
        chk("t3_lat", 128'(lat), 128'd17);
`ifdef MPADDER_FLAGS_EN
        chk("t3_zero", 128'(z), 128'h1);
`endif

        // Wide add: all ones + 1 carries out of the top
        runw(1'b0, {1024{1'b1}}, 1024'd1, rw, z, lat);
        chk("tw_ones_low", 128'(|rw[1023:0]), 128'h0);
        chk("tw_ones_carry", 128'(rw[1024]), 128'h1);

        // Wide random add and subtract, checked limb by limb
        for (int i = 0; i < 32; i++) begin
            wa[i*32 +: 32] = $urandom;
            wb[i*32 +: 32] = $urandom;
        end
        for (int op = 0; op < 2; op++) begin
            runw(op[0], wa[1023:0], wb[1023:0], rw, z, lat);
            if (op == 0) wexp = {63'b0, ({1'b0, wa[1023:0]} + {1'b0, wb[1023:0]})};
            else         wexp = {63'b0, ({1'b0, wa[1023:0]} - {1'b0, wb[1023:0]})};
            wres = {63'b0, rw};
            for (int i = 0; i < 17; i++)
                chk($sformatf("tw_op%0d_limb%0d", op, i),
                    128'(wres[i*64 +: 64]), 128'(wexp[i*64 +: 64]));
        end

        // Reset and start together: start is dropped
        rst = 1'b1; n_start = 1'b1; n_a = 8'h11; n_b = 8'h22;
        @(posedge clk); #1;
        rst = 1'b0; n_start = 1'b0;
        chk("rs_busy_now", 128'(n_busy), 128'h0);
        @(posedge clk); #1;
        chk("rs_busy_later", 128'(n_busy), 128'h0);
        chk("rs_done", 128'(n_done), 128'h0);

        // Test 6: single-limb unit, back-to-back ops
        run8(1'b0, 8'h80, 8'h80, r8, lat);
        chk("t6_res", 128'(r8), 128'h100);
        chk("t6_lat", 128'(lat), 128'd2);
        run8(1'b1, 8'h05, 8'h07, r8, lat);
        chk("t6_b2b_res", 128'(r8), 128'h1FE);
        chk("t6_b2b_lat", 128'(lat), 128'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
